// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: loads a burst of N 4-bit values, bubble-sorts them with a
// single shared comparator (one compare per clock), then streams them out
// smallest first over a valid/ready interface.
// Optional build macro: SORT_EARLY_EXIT_EN -- leave SORT after any pass that
// made no swap.

// 4-bit magnitude comparator (shared block, one instance per sequencer)
module comparator (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       A_grt_B,
  output logic       A_less_B,
  output logic       A_eq_B
);
  assign A_grt_B  = (A > B);
  assign A_less_B = (A < B);
  assign A_eq_B   = (A == B);
endmodule

module cmp_sort_ctrl #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic [5:0] swap_cnt
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] N2   = IW'(N - 2);

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_t;
  state_t state, state_nx;

  logic [3:0]    mem [N];
  logic [IW-1:0] ptr;      // write index in LOAD, read index in DRAIN
  logic [IW-1:0] idx, idx_p1, pass;
  logic          swapped;
  logic [3:0]    a_val, b_val;
  logic          a_grt_b, unused_less, unused_eq;
  logic          pass_end, sort_done;

  assign idx_p1 = idx + 1'b1;
  assign a_val  = mem[idx];
  assign b_val  = mem[idx_p1];

  comparator u_cmp (
    .A        (a_val),
    .B        (b_val),
    .A_grt_B  (a_grt_b),
    .A_less_B (unused_less),
    .A_eq_B   (unused_eq)
  );

  // Last compare of a pass covers the highest still-unsorted pair.
  assign pass_end = (idx == N2 - pass);
`ifdef SORT_EARLY_EXIT_EN
  // A pass with no swap (including this cycle's compare) means sorted.
  assign sort_done = pass_end && ((pass == N2) || !(swapped || a_grt_b));
`else
  assign sort_done = pass_end && (pass == N2);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nx;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 4'd0;
    busy      = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && ptr == LAST) state_nx = S_SORT;
      end
      S_SORT: begin
        busy = 1'b1;
        if (sort_done) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem[ptr];
        out_last  = (ptr == LAST);
        if (out_ready && ptr == LAST) state_nx = S_LOAD;
      end
      default: state_nx = S_LOAD;
    endcase
  end

  // Indices, pass bookkeeping and swap counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      idx      <= '0;
      pass     <= '0;
      swapped  <= 1'b0;
      swap_cnt <= 6'd0;
    end else begin
      case (state)
        S_LOAD: if (in_valid) begin
          if (ptr == LAST) begin
            ptr      <= '0;
            idx      <= '0;
            pass     <= '0;
            swapped  <= 1'b0;
            swap_cnt <= 6'd0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_SORT: begin
          if (a_grt_b) swap_cnt <= swap_cnt + 6'd1;
          if (pass_end) begin
            idx     <= '0;
            pass    <= pass + 1'b1;
            swapped <= 1'b0;
          end else begin
            idx     <= idx_p1;
            swapped <= swapped | a_grt_b;
          end
        end
        S_DRAIN: if (out_ready) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        default: ;
      endcase
    end
  end

  // Element storage: load writes and compare-driven swaps (contents need no reset)
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) begin
      mem[ptr] <= in_data;
    end else if (state == S_SORT && a_grt_b) begin
      mem[idx]    <= b_val;
      mem[idx_p1] <= a_val;
    end
  end
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Directed bench for cmp_sort_ctrl (N=4): table of bursts plus hand-written
// backpressure, reset and back-to-back sequences.
module tb_cmp_sort_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [3:0] in_data, out_data;
  logic [5:0] swap_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmp_sort_ctrl #(.N(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .swap_cnt(swap_cnt)
  );

  typedef struct {
    logic [3:0] din [4];
    logic [3:0] dout [4];
    int         swaps;
    int         cyc;
  } vec_t;

  vec_t tv [5];

`ifdef SORT_EARLY_EXIT_EN
  localparam int SORTED_CYC = 3;
`else
  localparam int SORTED_CYC = 6;
`endif

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input vec_t v, input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s in_ready[%0d]", tag, i), int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = v.din[i];
      tick();
    end
  endtask

  // hold: keep in_valid high with junk data throughout SORT
  task automatic sort_wait(input vec_t v, input string tag, input bit hold);
    int cnt = 0;
    in_valid = hold;
    in_data  = 4'hF;
    chk({tag, " busy in sort"}, int'(busy), 1);
    chk({tag, " in_ready in sort"}, int'(in_ready), 0);
    while (!out_valid && cnt < 100) begin
      if (hold) chk({tag, " in_ready held"}, int'(in_ready), 0);
      cnt++;
      tick();
    end
    in_valid = 1'b0;
    chk({tag, " sort cycles"}, cnt, v.cyc);
  endtask

  // bp_at: output index at which out_ready is held low for 3 cycles (-1 none)
  task automatic drain(input vec_t v, input string tag, input int bp_at);
    for (int i = 0; i < 4; i++) begin
      if (i == bp_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("%s bp data[%0d]", tag, k), int'(out_data), int'(v.dout[i]));
          chk($sformatf("%s bp valid[%0d]", tag, k), int'(out_valid), 1);
          chk($sformatf("%s bp last[%0d]", tag, k), int'(out_last), 0);
          tick();
        end
      end
      out_ready = 1'b1;
      chk($sformatf("%s valid[%0d]", tag, i), int'(out_valid), 1);
      chk($sformatf("%s data[%0d]", tag, i), int'(out_data), int'(v.dout[i]));
      chk($sformatf("%s last[%0d]", tag, i), int'(out_last), (i == 3) ? 1 : 0);
      tick();
    end
    out_ready = 1'b0;
    chk({tag, " in_ready after"}, int'(in_ready), 1);
    chk({tag, " busy after"}, int'(busy), 0);
    chk({tag, " out_valid after"}, int'(out_valid), 0);
    chk({tag, " swap_cnt"}, int'(swap_cnt), v.swaps);
  endtask

  logic [3:0] src [8];
  logic [3:0] got [8];
  logic       lst [8];

  initial begin
    tv[0].din = '{4'h9, 4'h3, 4'h7, 4'h1}; tv[0].dout = '{4'h1, 4'h3, 4'h7, 4'h9};
    tv[0].swaps = 5; tv[0].cyc = 6;
    tv[1].din = '{4'h1, 4'h2, 4'h3, 4'h4}; tv[1].dout = '{4'h1, 4'h2, 4'h3, 4'h4};
    tv[1].swaps = 0; tv[1].cyc = SORTED_CYC;
    tv[2].din = '{4'h5, 4'h5, 4'h2, 4'h5}; tv[2].dout = '{4'h2, 4'h5, 4'h5, 4'h5};
    tv[2].swaps = 2; tv[2].cyc = 6;
    tv[3].din = '{4'hF, 4'hE, 4'hD, 4'hC}; tv[3].dout = '{4'hC, 4'hD, 4'hE, 4'hF};
    tv[3].swaps = 6; tv[3].cyc = 6;
    tv[4].din = '{4'h8, 4'h6, 4'h4, 4'h2}; tv[4].dout = '{4'h2, 4'h4, 4'h6, 4'h8};
    tv[4].swaps = 6; tv[4].cyc = 6;

    rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
    tick(); tick();
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst out_last", int'(out_last), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst swap_cnt", int'(swap_cnt), 0);
    rst = 1'b0;
    tick();

    // table-driven bursts
    for (int t = 0; t < 4; t++) begin
      string tag = $sformatf("vec%0d", t);
      load(tv[t], tag);
      sort_wait(tv[t], tag, 1'b0);
      drain(tv[t], tag, -1);
    end

    // in_valid held through SORT, output stalled on the second element
    load(tv[0], "bp");
    sort_wait(tv[0], "bp", 1'b1);
    drain(tv[0], "bp", 1);

    // reset mid-DRAIN after two outputs
    load(tv[0], "rstm");
    sort_wait(tv[0], "rstm", 1'b0);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstm out_valid", int'(out_valid), 0);
    chk("rstm in_ready", int'(in_ready), 1);
    chk("rstm busy", int'(busy), 0);
    chk("rstm swap_cnt", int'(swap_cnt), 0);
    load(tv[4], "fresh");
    sort_wait(tv[4], "fresh", 1'b0);
    drain(tv[4], "fresh", -1);

    // back-to-back bursts, in_valid and out_ready tied high
    begin
      int k = 0, nout = 0, cyc = 0, c_acc = -1, c_last = -1;
      bit rdy;
      src = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h6, 4'h8, 4'h5, 4'h7};
      in_valid = 1'b1; out_ready = 1'b1;
      while (nout < 8 && cyc < 200) begin
        rdy = in_ready;
        if (k < 8) begin
          in_data = src[k];
          if (rdy && k == 4) c_acc = cyc;
        end else begin
          in_valid = 1'b0;
        end
        if (out_valid) begin
          got[nout] = out_data;
          lst[nout] = out_last;
          if (out_last && nout == 3) c_last = cyc;
          nout++;
        end
        tick();
        if (rdy && k < 8) k++;
        cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b outputs", nout, 8);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("b2b data[%0d]", i), (i < nout) ? int'(got[i]) : -1, i + 1);
        chk($sformatf("b2b last[%0d]", i), (i < nout) ? int'(lst[i]) : -1,
            (i == 3 || i == 7) ? 1 : 0);
      end
      chk("b2b accept cycle", c_acc, c_last + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
